// File: rtl/screen_sequencer.sv
// screen_sequencer: game-flow controller for text_display.
// Walks title -> key prompt -> per-level banner -> gameplay -> win screen.
// It tells the game datapath which level to load and when gameplay is live.
// Optional feature: define SCREEN_SEQ_SKIP_KEY_EN so that a key press skips
// the rest of a pre-level banner.
module screen_sequencer #(
   parameter int TITLE_FRAMES  = 60,
   parameter int BANNER_FRAMES = 120,
   parameter int CNT_W         = 8
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic       level_done,
   output logic       Init1_Active,
   output logic       Init2_Active,
   output logic       Wait_Before_Level1,
   output logic       Wait_Before_Level2,
   output logic       Wait_Before_Level3,
   output logic       game_final,
   output logic       game_active,
   output logic [1:0] level,
   output logic       level_start
);

   typedef enum logic [2:0] {
      S_INIT1, S_INIT2, S_WAIT1, S_WAIT2, S_WAIT3, S_PLAY, S_FINAL
   } state_t;

   // Flag vector order: {Init1, Init2, Wait1, Wait2, Wait3, final, active}.
   localparam logic [6:0] FLAGS_RESET = 7'b1000000;

   localparam logic [CNT_W-1:0] TITLE_LAST  = CNT_W'(TITLE_FRAMES - 1);
   localparam logic [CNT_W-1:0] BANNER_LAST = CNT_W'(BANNER_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       level_q, level_d;
   logic             level_start_q, level_start_d;
   logic             key_prev_q, key_prev_d;
   logic [6:0]       flags_q, flags_d;

   logic key_now;
   logic key_edge;
   logic title_done;
   logic banner_done;
   logic banner_go;
   logic counting;

   assign key_now     = (keycode != 8'h00);
   assign key_edge    = key_now && !key_prev_q;
   assign title_done  = frame_tick && (cnt_q == TITLE_LAST);
   assign banner_done = frame_tick && (cnt_q == BANNER_LAST);

`ifdef SCREEN_SEQ_SKIP_KEY_EN
   // A fresh key press cuts the banner short; OR-ing with the timeout keeps a
   // coincident key and final tick down to a single transition.
   assign banner_go = banner_done || key_edge;
`else
   // Banners always run their full length; the keyboard is ignored here.
   assign banner_go = banner_done;
`endif

   // Next-state, level tracking and frame counter.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d       = state_q;
      level_d       = level_q;
      level_start_d = 1'b0;
      key_prev_d    = key_now;
      counting      = 1'b0;

      unique case (state_q)
         S_INIT1: begin
            counting = 1'b1;
            if (title_done) state_d = S_INIT2;
         end
         S_INIT2: begin
            if (key_edge) state_d = S_WAIT1;
         end
         S_WAIT1, S_WAIT2, S_WAIT3: begin
            counting = 1'b1;
            if (banner_go) begin
               state_d       = S_PLAY;
               level_start_d = 1'b1;
               case (state_q)
                  S_WAIT1: level_d = 2'd1;
                  S_WAIT2: level_d = 2'd2;
                  default: level_d = 2'd3;
               endcase
            end
         end
         S_PLAY: begin
            // frame_tick is meaningless during gameplay; level_done alone decides.
            if (level_done) begin
               case (level_q)
                  2'd0:    state_d = S_WAIT1;
                  2'd1:    state_d = S_WAIT2;
                  2'd2:    state_d = S_WAIT3;
                  default: state_d = S_FINAL;
               endcase
            end
         end
         S_FINAL: begin
            if (key_edge) begin
               state_d = S_INIT1;
               level_d = 2'd0;
            end
         end
         default: begin
            state_d = S_INIT1;
            level_d = 2'd0;
         end
      endcase

      // Every state change restarts the frame count; it saturates instead of wrapping.
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (counting && frame_tick && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Decode the screen flags from the next state so the outputs come straight from flops.
   always_comb begin
      flags_d = FLAGS_RESET;
      unique case (state_d)
         S_INIT1: flags_d = 7'b1000000;
         S_INIT2: flags_d = 7'b0100000;
         S_WAIT1: flags_d = 7'b0010000;
         S_WAIT2: flags_d = 7'b0001000;
         S_WAIT3: flags_d = 7'b0000100;
         S_FINAL: flags_d = 7'b0000010;
         S_PLAY:  flags_d = 7'b0000001;
         default: flags_d = FLAGS_RESET;
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q       <= S_INIT1;
         cnt_q         <= '0;
         level_q       <= 2'd0;
         level_start_q <= 1'b0;
         key_prev_q    <= 1'b0;
         flags_q       <= FLAGS_RESET;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         level_q       <= level_d;
         level_start_q <= level_start_d;
         key_prev_q    <= key_prev_d;
         flags_q       <= flags_d;
      end
   end

   assign Init1_Active       = flags_q[6];
   assign Init2_Active       = flags_q[5];
   assign Wait_Before_Level1 = flags_q[4];
   assign Wait_Before_Level2 = flags_q[3];
   assign Wait_Before_Level3 = flags_q[2];
   assign game_final         = flags_q[1];
   assign game_active        = flags_q[0];
   assign level              = level_q;
   assign level_start        = level_start_q;

endmodule
